adc_seq_ctrl: RTL
=================

Name: adc_seq_ctrl

Overview:
Controller that sequences the on-chip modular ADC for temperature readout. It performs the following steps:
- Issues sequencer CSR run/stop commands.
- Filters response beats by channel.
- Averages 2^AVG_LOG2 samples per result.
- Writes each result into a sample RAM through a circular address pointer.

It sits between the ADC instance, the sample RAM and the board LEDs in the temperature-readout top level.

Parameters:
AVG_LOG2, 3, log2 of samples averaged per result (1..6)
RAM_AW, 8, sample RAM address width
CH_SEL, 17, ADC response channel accepted (temperature sensor)
SEQ_MODE, 0, sequencer mode field written on start (0 = continuous)
TIMEOUT_CYC, 4096, watchdog limit in clk cycles (used only with ADC_TIMEOUT_EN)

Ports:
clk  in  1  system clock, same clock as the ADC CSR/response interfaces
rst  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins acquisition when idle
stop  in  1  one-cycle pulse; requests halt at the end of the current average block
csr_address  out  1  sequencer CSR address (always 0 = command register)
csr_write  out  1  one-cycle CSR write strobe
csr_writedata  out  32  {28'b0, mode[2:0], run}
resp_valid  in  1  ADC response valid
resp_channel  in  5  ADC response channel
resp_data  in  12  ADC response sample
ram_we  out  1  RAM write enable
ram_addr  out  RAM_AW  RAM write address
ram_wdata  out  12  averaged sample
avg_valid  out  1  pulses with each new average
avg_data  out  12  last average, held between updates
led_dout  out  8  avg_data[11:4]
busy  out  1  high in any state except IDLE
wrapped  out  1  sticky; set when ram_addr wraps max->0, cleared on start
err  out  1  sticky timeout flag (0 when ADC_TIMEOUT_EN undefined)

Behaviour:
- Reset (rst low, asynchronous): state IDLE; all outputs 0; accumulator, sample count, address and stop latch cleared.
- FSM states: IDLE, RUN_CMD, ACQ, STORE, STOP_CMD.
- IDLE: start=1 -> RUN_CMD. wrapped and err are cleared on start. stop is ignored in IDLE.
- RUN_CMD: one cycle. Outputs csr_write=1, csr_address=0, csr_writedata={28'b0,SEQ_MODE[2:0],1'b1}. -> ACQ. The CSR has no waitrequest; a single-cycle write is always accepted.
- ACQ, beat acceptance: a beat is accepted only when resp_valid=1 and resp_channel==CH_SEL. Other beats are ignored.
- ACQ, accumulation: accepted data adds into an accumulator of width 12+AVG_LOG2 (no overflow possible). The sample count increments.
- ACQ, block completion: on the accepted beat that completes 2^AVG_LOG2 samples (cycle t):
  - avg_data <= (acc + resp_data) >> AVG_LOG2, truncating.
  - State -> STORE at the t edge.
- STORE: exactly one cycle (t+1). ram_we=1, avg_valid=1, ram_wdata=avg_data, ram_addr=current pointer. At the following edge:
  - Pointer increments, wrapping 2^RAM_AW-1 -> 0 and setting wrapped.
  - Accumulator and count are cleared.
  - Next state is STOP_CMD if the stop latch is set, else ACQ.
- Responses during STORE, RUN_CMD or STOP_CMD are dropped.
- stop pulse in RUN_CMD/ACQ/STORE sets the stop latch. The current block completes before halting. Partial blocks are never written.
- start while busy is ignored. start and stop in the same cycle in IDLE: start wins, and the stop latch is set.
- STOP_CMD: one cycle. csr_write=1, csr_writedata=0 (run=0). Stop latch cleared. -> IDLE.
- ram_addr is not reset by start. It continues circularly across runs and is cleared only by rst.
- Reset mid-operation: immediate return to IDLE. No stop command is issued, because the ADC shares rst.
- Outputs csr_*, ram_we and avg_valid are registered.

Optional Feature:
ADC_TIMEOUT_EN: when defined, a watchdog counter runs in ACQ.
- The counter clears on each accepted beat and on entry to ACQ.
- On reaching TIMEOUT_CYC: set err, discard the partial block, go to STOP_CMD.

When ADC_TIMEOUT_EN is undefined, no counter exists, err is tied 0, and ACQ waits indefinitely.

Test Plan:
- Reset, start pulse -> next cycle csr_write=1 with writedata 0x00000001, then ACQ; busy=1.
- 8 beats ch17 with data 100..107 -> one cycle after the 8th beat: ram_we=1, ram_addr=0, ram_wdata=103 (0x067), avg_valid=1, led_dout=0x06.
- Beats interleaved with ch5 data 0xFFF -> ch5 ignored; average of the eight ch17 beats of 0x800 is 0x800.
- stop after the 3rd beat of a block -> 5 more ch17 beats complete the block; one RAM write, then csr_write=1 with writedata 0, then IDLE; busy=0.
- RAM_AW=2, 5 blocks -> addresses 0,1,2,3,0; wrapped set at the 4th->5th transition.
- ADC_TIMEOUT_EN defined, TIMEOUT_CYC=16, no beats after start -> err=1 about 16 cycles after ACQ entry, stop command issued, no ram_we.

Source files
------------

// File: rtl/adc_seq_ctrl.sv
// -----------------------------------------------------------------------------
// adc_seq_ctrl
//
// Sequences the on-chip modular ADC for temperature readout. Starts the
// sequencer through its command CSR, accepts response beats from a single
// channel, averages 2^AVG_LOG2 samples per result and writes each result into
// a sample RAM through a circular address pointer. The latest result is also
// shown on the board LEDs.
//
// Optional build macro:
//   ADC_TIMEOUT_EN  - adds an acquisition watchdog. When no accepted beat is
//                     seen for TIMEOUT_CYC cycles, err is set, the partial
//                     block is discarded and the sequencer is stopped.
//                     Undefined: err is tied low and ACQ waits indefinitely.
//
// Ports:
//   clk, rst        system clock; asynchronous active-low reset
//   start, stop     one-cycle control pulses
//   csr_*           sequencer command register write (address always 0)
//   resp_*          ADC response stream (valid / channel / 12-bit sample)
//   ram_*           sample RAM write port
//   avg_valid       pulses once per new average
//   avg_data        last average, held between updates
//   led_dout        avg_data[11:4]
//   busy            high whenever the controller is not idle
//   wrapped         sticky, set when the RAM pointer wraps; cleared on start
//   err             sticky watchdog timeout flag
// -----------------------------------------------------------------------------
module adc_seq_ctrl #(
  parameter int AVG_LOG2    = 3,
  parameter int RAM_AW      = 8,
  parameter int CH_SEL      = 17,
  parameter int SEQ_MODE    = 0,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  output logic              csr_address,
  output logic              csr_write,
  output logic [31:0]       csr_writedata,
  input  logic              resp_valid,
  input  logic [4:0]        resp_channel,
  input  logic [11:0]       resp_data,
  output logic              ram_we,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [11:0]       ram_wdata,
  output logic              avg_valid,
  output logic [11:0]       avg_data,
  output logic [7:0]        led_dout,
  output logic              busy,
  output logic              wrapped,
  output logic              err
);

  localparam int ACC_W = 12 + AVG_LOG2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN_CMD,
    S_ACQ,
    S_STORE,
    S_STOP_CMD
  } state_t;

  state_t               state, next_state;
  logic [ACC_W-1:0]     acc;
  logic [ACC_W-1:0]     acc_sum;
  logic [AVG_LOG2-1:0]  cnt;
  logic                 stop_latch;
  logic                 accept;
  logic                 block_done;
  logic                 timeout_hit;

  // Registered-output next values, derived from the next state so each
  // strobe is high exactly during the cycle spent in the matching state.
  logic                 csr_write_d;
  logic [31:0]          csr_writedata_d;
  logic                 store_d;

  assign accept     = (state == S_ACQ) && resp_valid && (resp_channel == 5'(CH_SEL));
  assign acc_sum    = acc + ACC_W'(resp_data);
  assign block_done = accept && (cnt == '1);

  // ---------------------------------------------------------------------------
  // Optional watchdog
  // ---------------------------------------------------------------------------
`ifdef ADC_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  logic [WD_W-1:0] wd_cnt;

  // Counter is held at zero outside ACQ, so entering ACQ starts it fresh.
  assign timeout_hit = (state == S_ACQ) && !accept && (wd_cnt == WD_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_cnt <= '0;
      err    <= 1'b0;
    end else begin
      if (state != S_ACQ || accept) wd_cnt <= '0;
      else                          wd_cnt <= wd_cnt + 1'b1;

      if (state == S_IDLE && start) err <= 1'b0;
      else if (timeout_hit)         err <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign err         = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= next_state;
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: default first, so no path leaves next_state unassigned (no latch).
    next_state = state;
    unique case (state)
      S_IDLE:     if (start) next_state = S_RUN_CMD;
      S_RUN_CMD:  next_state = S_ACQ;
      S_ACQ: begin
        if (block_done)       next_state = S_STORE;
        else if (timeout_hit) next_state = S_STOP_CMD;
      end
      // A stop arriving in the STORE cycle itself must still halt after this
      // block, so the live pulse is considered alongside the latch.
      S_STORE:    next_state = (stop_latch || stop) ? S_STOP_CMD : S_ACQ;
      S_STOP_CMD: next_state = S_IDLE;
      default:    next_state = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: output logic (next values of the registered strobes)
  // ---------------------------------------------------------------------------
  always_comb begin
    csr_write_d     = 1'b0;
    csr_writedata_d = 32'd0;
    store_d         = 1'b0;
    unique case (next_state)
      S_RUN_CMD: begin
        csr_write_d     = 1'b1;
        csr_writedata_d = {28'd0, 3'(SEQ_MODE), 1'b1};
      end
      S_STOP_CMD: csr_write_d = 1'b1;
      S_STORE:    store_d     = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      csr_write     <= 1'b0;
      csr_writedata <= 32'd0;
      ram_we        <= 1'b0;
      avg_valid     <= 1'b0;
    end else begin
      csr_write     <= csr_write_d;
      csr_writedata <= csr_writedata_d;
      ram_we        <= store_d;
      avg_valid     <= store_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath: accumulator, average, RAM pointer, sticky flags
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc        <= '0;
      cnt        <= '0;
      avg_data   <= 12'd0;
      ram_addr   <= '0;
      wrapped    <= 1'b0;
      stop_latch <= 1'b0;
    end else begin
      // Completing beat is folded into acc too; STORE clears it next cycle.
      if (state == S_STORE || timeout_hit) begin
        acc <= '0;
        cnt <= '0;
      end else if (accept) begin
        acc <= acc_sum;
        cnt <= cnt + 1'b1;
      end

      if (block_done) avg_data <= acc_sum[ACC_W-1:AVG_LOG2];

      // Pointer is never cleared by start: it runs circularly across runs.
      if (state == S_STORE) ram_addr <= ram_addr + 1'b1;

      if (state == S_IDLE && start)                   wrapped <= 1'b0;
      else if (state == S_STORE && ram_addr == '1)    wrapped <= 1'b1;

      if (state == S_STOP_CMD)
        stop_latch <= 1'b0;
      else if (stop && (state != S_IDLE || start))
        stop_latch <= 1'b1;
    end
  end

  assign csr_address = 1'b0;
  assign ram_wdata   = avg_data;
  assign led_dout    = avg_data[11:4];
  assign busy        = (state != S_IDLE);

endmodule
